// File: rtl/shooter_pkg.sv
// Shared types and screen constants for the shooter game stages.
// Game FSM encoding, BCD digit type and vertical play-field bounds.
package shooter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PLAY   = 2'd1,
      PAUSED = 2'd2,
      OVER   = 2'd3
   } game_state_t;

   typedef logic [3:0] bcd_digit_t;

   localparam int unsigned BOUND_UP   = 31;
   localparam int unsigned BOUND_DOWN = 511;

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD incrementer, saturating at 9999; clr has priority over inc.
// Latency: q updates on the edge that samples inc/clr. No backpressure.
module bcd_counter4
   import shooter_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   input  logic        clr,
   output logic [15:0] q
);

   logic [15:0] cnt_q, cnt_d;
   logic        carry;
   bcd_digit_t  dig;

   always_comb begin
      cnt_d = cnt_q;
      carry = 1'b1;
      dig   = '0;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != 16'h9999)) begin
         // Ripple the +1 from the units digit until a digit absorbs it.
         for (int i = 0; i < 4; i++) begin
            dig = cnt_q[i*4 +: 4];
            if (carry) begin
               if (dig == 4'd9) begin
                  cnt_d[i*4 +: 4] = 4'd0;
               end else begin
                  cnt_d[i*4 +: 4] = dig + 4'd1;
                  carry           = 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign q = cnt_q;

endmodule

// File: rtl/wave_speed_ctrl.sv
// Score/level controller for the wave enemy; maps kill-driven level to a movement divisor.
// Latency: score/level at the hit-sampling edge, wave_speed/level_up one edge later. No backpressure.
module wave_speed_ctrl
   import shooter_pkg::*;
#(
   parameter logic [23:0] BASE_SPEED      = 24'd400000,
   parameter logic [23:0] SPEED_STEP      = 24'd30000,
   parameter logic [23:0] MIN_SPEED       = 24'd100000,
   parameter int unsigned KILLS_PER_LEVEL = 10,
   parameter int unsigned MAX_LEVEL       = 9
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        pause,
   input  logic        game_start_on,
   input  logic        game_over_on,
   input  logic        hit_w_enemy,
   input  logic        enemy_active,
   output logic [23:0] wave_speed,
   output logic [15:0] score,
   output logic [3:0]  level,
   output logic        level_up
);

   localparam logic [3:0] KILL_WRAP = 4'(KILLS_PER_LEVEL - 1);
   localparam logic [3:0] LEVEL_TOP = 4'(MAX_LEVEL);

   game_state_t state_q, state_d;
   logic        hit_q;
   logic        armed_q, armed_d;
   logic [3:0]  kills_q, kills_d;
   logic [3:0]  level_q, level_d;
   logic        lvl_inc;
   logic        lvl_inc_q;
   logic        level_up_q;
   logic [23:0] speed_q;
   logic        kill;
   logic        start_game;

   // Clamp before subtracting so a large level*step can never wrap below zero.
   function automatic logic [23:0] speed_for_level(input logic [3:0] lvl);
      logic [27:0] prod;
      prod = 28'(lvl) * 28'(SPEED_STEP);
      if (prod >= 28'(BASE_SPEED - MIN_SPEED)) begin
         return MIN_SPEED;
      end
      return BASE_SPEED - prod[23:0];
   endfunction

   assign kill       = hit_w_enemy & ~hit_q & armed_q & enemy_active & (state_q == PLAY);
   assign start_game = (state_q == IDLE) & ~game_start_on & ~game_over_on;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_game)        state_d = PLAY;
         PLAY:    if (game_over_on)      state_d = OVER;
                  else if (pause)        state_d = PAUSED;
         PAUSED:  if (game_over_on)      state_d = OVER;
                  else if (!pause)       state_d = PLAY;
         OVER:    if (game_start_on)     state_d = IDLE;
         default:                        state_d = IDLE;
      endcase
   end

   always_comb begin
      armed_d = armed_q;
      kills_d = kills_q;
      level_d = level_q;
      lvl_inc = 1'b0;
      if (start_game) begin
         armed_d = 1'b1;
         kills_d = '0;
         level_d = '0;
      end else begin
         // One kill per enemy life: re-arm only once the enemy is seen dead.
         if (kill) begin
            armed_d = 1'b0;
         end else if (!enemy_active) begin
            armed_d = 1'b1;
         end
         if (kill) begin
            if (kills_q == KILL_WRAP) begin
               kills_d = '0;
               if (level_q < LEVEL_TOP) begin
                  level_d = level_q + 4'd1;
                  lvl_inc = 1'b1;
               end
            end else begin
               kills_d = kills_q + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         hit_q      <= 1'b0;
         armed_q    <= 1'b1;
         kills_q    <= '0;
         level_q    <= '0;
         lvl_inc_q  <= 1'b0;
         level_up_q <= 1'b0;
         speed_q    <= BASE_SPEED;
      end else begin
         state_q    <= state_d;
         hit_q      <= hit_w_enemy;
         armed_q    <= armed_d;
         kills_q    <= kills_d;
         level_q    <= level_d;
         lvl_inc_q  <= lvl_inc;
         level_up_q <= lvl_inc_q;
         speed_q    <= speed_for_level(level_q);
      end
   end

   bcd_counter4 u_score (
      .clk (clk),
      .rst (rst),
      .inc (kill),
      .clr (start_game),
      .q   (score)
   );

   assign wave_speed = speed_q;
   assign level      = level_q;
   assign level_up   = level_up_q;

endmodule

// File: tb/tb_wave_speed_ctrl.sv
// Bench for wave_speed_ctrl: scoreboarded kill sequences plus gating, saturation and reset scenarios.
module tb_wave_speed_ctrl;
   import shooter_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        pause;
   logic        game_start_on;
   logic        game_over_on;
   logic        hit_w_enemy;
   logic        enemy_active;
   logic [23:0] wave_speed, wave_speed2;
   logic [15:0] score, score2;
   logic [3:0]  level, level2;
   logic        level_up, level_up2;

   int n_checks = 0;
   int n_errors = 0;

   int m_score;
   int m_kc;
   int m_level;

   typedef struct packed {
      logic [15:0] score;
      logic [3:0]  level;
      logic        lvl_up;
      logic [23:0] spd;
      logic [23:0] spd2;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   wave_speed_ctrl dut (
      .clk(clk), .rst(rst), .pause(pause), .game_start_on(game_start_on),
      .game_over_on(game_over_on), .hit_w_enemy(hit_w_enemy), .enemy_active(enemy_active),
      .wave_speed(wave_speed), .score(score), .level(level), .level_up(level_up)
   );

   wave_speed_ctrl #(.SPEED_STEP(24'd50000)) dut2 (
      .clk(clk), .rst(rst), .pause(pause), .game_start_on(game_start_on),
      .game_over_on(game_over_on), .hit_w_enemy(hit_w_enemy), .enemy_active(enemy_active),
      .wave_speed(wave_speed2), .score(score2), .level(level2), .level_up(level_up2)
   );

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   function automatic logic [23:0] spd_model(input int lvl, input int step);
      int v;
      v = 400000 - lvl * step;
      if (v < 100000) v = 100000;
      return 24'(v);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Phase 0 fires a kill, phase 1 lets the enemy die and re-arms.
   task automatic kill_once();
      exp_t e;
      int   prev_lvl;
      bit   inc;
      for (int ph = 0; ph < 2; ph++) begin
         if (ph == 0) begin
            prev_lvl     = m_level;
            inc          = 1'b0;
            hit_w_enemy  = 1'b1;
            enemy_active = 1'b1;
            if (m_score < 9999) m_score++;
            if (m_kc == 9) begin
               m_kc = 0;
               if (m_level < 9) begin
                  m_level++;
                  inc = 1'b1;
               end
            end else begin
               m_kc++;
            end
            e.lvl_up = 1'b0;
            e.spd    = spd_model(prev_lvl, 30000);
            e.spd2   = spd_model(prev_lvl, 50000);
         end else begin
            hit_w_enemy  = 1'b0;
            enemy_active = 1'b0;
            e.lvl_up = inc;
            e.spd    = spd_model(m_level, 30000);
            e.spd2   = spd_model(m_level, 50000);
         end
         e.score = to_bcd(m_score);
         e.level = 4'(m_level);
         sb_q.push_back(e);
         tick();
         e = sb_q.pop_front();
         n_checks++;
         if (score !== e.score) begin
            n_errors++;
            $display("FAIL kill_score ph%0d: got %h expected %h", ph, score, e.score);
         end
         n_checks++;
         if (level !== e.level) begin
            n_errors++;
            $display("FAIL kill_level ph%0d: got %0d expected %0d", ph, level, e.level);
         end
         n_checks++;
         if (level_up !== e.lvl_up) begin
            n_errors++;
            $display("FAIL kill_level_up ph%0d: got %b expected %b", ph, level_up, e.lvl_up);
         end
         n_checks++;
         if (wave_speed !== e.spd) begin
            n_errors++;
            $display("FAIL kill_speed ph%0d: got %0d expected %0d", ph, wave_speed, e.spd);
         end
         n_checks++;
         if (wave_speed2 !== e.spd2) begin
            n_errors++;
            $display("FAIL kill_speed_step50k ph%0d: got %0d expected %0d", ph, wave_speed2, e.spd2);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; pause = 1'b0; game_start_on = 1'b1; game_over_on = 1'b0;
      hit_w_enemy = 1'b0; enemy_active = 1'b0;
      repeat (3) tick();
      n_checks++;
      if (wave_speed !== 24'd400000) begin n_errors++; $display("FAIL reset_speed: got %0d expected 400000", wave_speed); end
      n_checks++;
      if (wave_speed2 !== 24'd400000) begin n_errors++; $display("FAIL reset_speed2: got %0d expected 400000", wave_speed2); end
      n_checks++;
      if (score !== 16'h0000) begin n_errors++; $display("FAIL reset_score: got %h expected 0000", score); end
      n_checks++;
      if (level !== 4'd0) begin n_errors++; $display("FAIL reset_level: got %0d expected 0", level); end
      n_checks++;
      if (level_up !== 1'b0) begin n_errors++; $display("FAIL reset_level_up: got %b expected 0", level_up); end
      n_checks++;
      if (dut.state_q !== IDLE) begin n_errors++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE); end
      rst = 1'b1;
      tick();
   endtask

   task automatic start_game();
      game_start_on = 1'b0;
      game_over_on  = 1'b0;
      tick();
      m_score = 0; m_kc = 0; m_level = 0;
      n_checks++;
      if (dut.state_q !== PLAY) begin n_errors++; $display("FAIL start_state: got %0d expected %0d", dut.state_q, PLAY); end
      n_checks++;
      if (score !== 16'h0000) begin n_errors++; $display("FAIL start_score: got %h expected 0000", score); end
   endtask

   task automatic test_single_kill();
      hit_w_enemy = 1'b0; enemy_active = 1'b1;
      tick();
      hit_w_enemy = 1'b1;
      m_score = 1; m_kc = 1;
      tick();
      n_checks++;
      if (score !== 16'h0001) begin n_errors++; $display("FAIL single_kill_first: got %h expected 0001", score); end
      repeat (39) tick();
      n_checks++;
      if (score !== 16'h0001) begin n_errors++; $display("FAIL single_kill_held: got %h expected 0001", score); end
      hit_w_enemy = 1'b0; enemy_active = 1'b0;
      tick();
   endtask

   task automatic test_level_up();
      repeat (9) kill_once();
      tick();
      n_checks++;
      if (level !== 4'd1) begin n_errors++; $display("FAIL level_up_level: got %0d expected 1", level); end
      n_checks++;
      if (level_up !== 1'b0) begin n_errors++; $display("FAIL level_up_single: got %b expected 0", level_up); end
      n_checks++;
      if (wave_speed !== 24'd370000) begin n_errors++; $display("FAIL level_up_speed: got %0d expected 370000", wave_speed); end
   endtask

   task automatic test_gating();
      pause = 1'b1;
      tick();
      hit_w_enemy = 1'b1; enemy_active = 1'b1;
      tick();
      n_checks++;
      if (score !== to_bcd(m_score)) begin n_errors++; $display("FAIL gate_pause: got %h expected %h", score, to_bcd(m_score)); end
      n_checks++;
      if (dut.state_q !== PAUSED) begin n_errors++; $display("FAIL gate_pause_state: got %0d expected %0d", dut.state_q, PAUSED); end
      hit_w_enemy = 1'b0; pause = 1'b0;
      tick();
      kill_once();

      hit_w_enemy = 1'b1; enemy_active = 1'b0;
      tick();
      n_checks++;
      if (score !== to_bcd(m_score)) begin n_errors++; $display("FAIL gate_inactive: got %h expected %h", score, to_bcd(m_score)); end
      enemy_active = 1'b1;
      tick();
      n_checks++;
      if (score !== to_bcd(m_score)) begin n_errors++; $display("FAIL gate_held_respawn: got %h expected %h", score, to_bcd(m_score)); end
      hit_w_enemy = 1'b0;
      tick();
      kill_once();

      game_over_on = 1'b1;
      kill_once();
      n_checks++;
      if (dut.state_q !== OVER) begin n_errors++; $display("FAIL gate_over_state: got %0d expected %0d", dut.state_q, OVER); end
      hit_w_enemy = 1'b1; enemy_active = 1'b1;
      tick();
      n_checks++;
      if (score !== 16'h0013) begin n_errors++; $display("FAIL gate_over_hit: got %h expected 0013", score); end
      hit_w_enemy = 1'b0; enemy_active = 1'b0; game_start_on = 1'b1;
      tick();
      game_over_on = 1'b0;
      tick();
      n_checks++;
      if (dut.state_q !== IDLE) begin n_errors++; $display("FAIL gate_idle_state: got %0d expected %0d", dut.state_q, IDLE); end
      n_checks++;
      if (score !== 16'h0013) begin n_errors++; $display("FAIL gate_idle_score_held: got %h expected 0013", score); end
      n_checks++;
      if (level !== 4'd1) begin n_errors++; $display("FAIL gate_idle_level_held: got %0d expected 1", level); end
      start_game();
      n_checks++;
      if (level !== 4'd0) begin n_errors++; $display("FAIL gate_restart_level: got %0d expected 0", level); end
   endtask

   task automatic test_saturation();
      repeat (100) kill_once();
      n_checks++;
      if (level !== 4'd9) begin n_errors++; $display("FAIL sat_level: got %0d expected 9", level); end
      n_checks++;
      if (wave_speed !== 24'd130000) begin n_errors++; $display("FAIL sat_speed: got %0d expected 130000", wave_speed); end
      n_checks++;
      if (wave_speed2 !== 24'd100000) begin n_errors++; $display("FAIL sat_speed_clamp: got %0d expected 100000", wave_speed2); end
      while (m_score < 9998) kill_once();
      repeat (3) kill_once();
      n_checks++;
      if (score !== 16'h9999) begin n_errors++; $display("FAIL sat_score: got %h expected 9999", score); end
   endtask

   task automatic test_async_reset();
      game_over_on = 1'b1;
      tick();
      game_over_on = 1'b0; game_start_on = 1'b1;
      tick();
      start_game();
      repeat (50) kill_once();
      n_checks++;
      if (level !== 4'd5) begin n_errors++; $display("FAIL arst_pre_level: got %0d expected 5", level); end
      n_checks++;
      if (level_up !== 1'b1) begin n_errors++; $display("FAIL arst_pre_level_up: got %b expected 1", level_up); end
      #1 rst = 1'b0;
      #1;
      n_checks++;
      if (wave_speed !== 24'd400000) begin n_errors++; $display("FAIL arst_speed: got %0d expected 400000", wave_speed); end
      n_checks++;
      if (score !== 16'h0000) begin n_errors++; $display("FAIL arst_score: got %h expected 0000", score); end
      n_checks++;
      if (level !== 4'd0) begin n_errors++; $display("FAIL arst_level: got %0d expected 0", level); end
      n_checks++;
      if (level_up !== 1'b0) begin n_errors++; $display("FAIL arst_level_up: got %b expected 0", level_up); end
      n_checks++;
      if (dut.state_q !== IDLE) begin n_errors++; $display("FAIL arst_state: got %0d expected %0d", dut.state_q, IDLE); end
      tick();
      rst = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      start_game();
      test_single_kill();
      test_level_up();
      test_gating();
      test_saturation();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
